strat_param_ram_arb: RTL

Single-port per-symbol parameter RAM. Arbitrates between three requesters:
- feed-decoder symbol lookups (highest priority, never stalled);
- buffered host writes;
- host read-back.
Successor to the current single-write-strobe RAM controller. Adds parametrised width/depth, a host write queue with valid/ready, a host read-back port and write-stall statistics. Sits between the feed decoder/host programming block and the strategy comparator.

---
 rtl/strat_param_ram_arb.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/strat_param_ram_arb.sv
// rtl/strat_param_ram_arb.sv - single-port per-symbol parameter RAM with feed/host-write/host-read arbitration
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   rd_valid/rd_addr      feed-decoder lookup (highest priority, never stalled)
//   rd_data_valid/rd_data feed lookup result (registered, holds while valid low)
//   wr_valid/wr_ready     host write handshake into the write queue
//   wr_addr/wr_data/wr_be host write payload; wr_be bit i covers data[8i+7:8i]
//   wr_done               one-cycle pulse per write committed to RAM
//   hst_rd_req/hst_rd_addr host read-back request, held until hst_rd_ack
//   hst_rd_ack            one-cycle grant pulse (address sampled in this cycle)
//   hst_rd_valid/hst_rd_data host read-back result (registered, holds while valid low)
//   wq_level              write queue occupancy
//   wr_stall_max          longest run of cycles a queued write lost to feed lookups (saturating)
module strat_param_ram_arb #(
    parameter int RAM_WIDTH = 64,
    parameter int ADDR_W    = 14,
    localparam int BE_W     = RAM_WIDTH / 8,
    parameter int WQ_DEPTH  = 4,
    parameter int REG_ADDR  = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rd_valid,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic                          rd_data_valid,
    output logic [RAM_WIDTH-1:0]          rd_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [RAM_WIDTH-1:0]          wr_data,
    input  logic [BE_W-1:0]               wr_be,
    output logic                          wr_done,
    input  logic                          hst_rd_req,
    input  logic [ADDR_W-1:0]             hst_rd_addr,
    output logic                          hst_rd_ack,
    output logic                          hst_rd_valid,
    output logic [RAM_WIDTH-1:0]          hst_rd_data,
    output logic [$clog2(WQ_DEPTH):0]     wq_level,
    output logic [15:0]                   wr_stall_max
);

    localparam int PW    = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
    localparam int LW    = $clog2(WQ_DEPTH) + 1;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {OP_NONE, OP_FEED, OP_WR, OP_HST} op_t;

    // ---------------- host write queue ----------------
    logic [ADDR_W-1:0]    q_addr [WQ_DEPTH];
    logic [RAM_WIDTH-1:0] q_data [WQ_DEPTH];
    logic [BE_W-1:0]      q_be   [WQ_DEPTH];
    logic [PW-1:0]        wp, rp;
    logic                 push, pop, q_nonempty;

    assign wr_ready   = (wq_level != LW'(WQ_DEPTH));
    assign q_nonempty = (wq_level != '0);
    assign push       = wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp       <= '0;
            rp       <= '0;
            wq_level <= '0;
        end else begin
            if (push) begin
                q_addr[wp] <= wr_addr;
                q_data[wp] <= wr_data;
                q_be[wp]   <= wr_be;
                wp         <= wp + PW'(1);
            end
            if (pop) begin
                rp <= rp + PW'(1);
            end
            // Level is taken before the push, so a full queue never pushes even when it pops.
            case ({push, pop})
                2'b10:   wq_level <= wq_level + LW'(1);
                2'b01:   wq_level <= wq_level - LW'(1);
                default: wq_level <= wq_level;
            endcase
        end
    end

    // ---------------- fixed-priority arbiter ----------------
    op_t                  req_op;
    logic [ADDR_W-1:0]    req_addr;
    logic [RAM_WIDTH-1:0] req_data;
    logic [BE_W-1:0]      req_be;

    always_comb begin
        req_op     = OP_NONE;
        req_addr   = rd_addr;
        req_data   = q_data[rp];
        req_be     = q_be[rp];
        hst_rd_ack = 1'b0;
        // Nothing is granted in a reset cycle so no op escapes the flush.
        if (!reset) begin
            if (rd_valid) begin
                req_op   = OP_FEED;
                req_addr = rd_addr;
            end else if (q_nonempty) begin
                req_op   = OP_WR;
                req_addr = q_addr[rp];
            end else if (hst_rd_req) begin
                req_op     = OP_HST;
                req_addr   = hst_rd_addr;
                hst_rd_ack = 1'b1;
            end
        end
    end

    assign pop = (req_op == OP_WR);

    // ---------------- optional request register ----------------
    op_t                  acc_op;
    logic [ADDR_W-1:0]    acc_addr;
    logic [RAM_WIDTH-1:0] acc_data;
    logic [BE_W-1:0]      acc_be;

    generate
        if (REG_ADDR != 0) begin : g_reg_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_op <= OP_NONE;
                end else begin
                    acc_op <= req_op;
                end
                acc_addr <= req_addr;
                acc_data <= req_data;
                acc_be   <= req_be;
            end
        end else begin : g_direct
            assign acc_op   = req_op;
            assign acc_addr = req_addr;
            assign acc_data = req_data;
            assign acc_be   = req_be;
        end
    endgenerate

    // ---------------- RAM array and registered read/ack outputs ----------------
    logic [RAM_WIDTH-1:0] mem [DEPTH];

    // A staged write sitting in the register during reset is dropped here.
    always_ff @(posedge clk) begin
        if (!reset && acc_op == OP_WR) begin
            for (int b = 0; b < BE_W; b++) begin
                if (acc_be[b]) begin
                    mem[acc_addr][8*b +: 8] <= acc_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
            hst_rd_valid  <= 1'b0;
            hst_rd_data   <= '0;
            wr_done       <= 1'b0;
        end else begin
            rd_data_valid <= (acc_op == OP_FEED);
            hst_rd_valid  <= (acc_op == OP_HST);
            wr_done       <= (acc_op == OP_WR);
            if (acc_op == OP_FEED) begin
                rd_data <= mem[acc_addr];
            end
            if (acc_op == OP_HST) begin
                hst_rd_data <= mem[acc_addr];
            end
        end
    end

    // ---------------- write stall statistics ----------------
    logic [15:0] stall_cnt, stall_next;

    always_comb begin
        stall_next = stall_cnt;
        if (pop) begin
            stall_next = '0;
        end else if (q_nonempty && rd_valid && stall_cnt != 16'hFFFF) begin
            stall_next = stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt    <= '0;
            wr_stall_max <= '0;
        end else begin
            stall_cnt <= stall_next;
            if (stall_next > wr_stall_max) begin
                wr_stall_max <= stall_next;
            end
        end
    end

endmodule
